// File: rtl/signed_accum_adder_if.sv
// Operand/result bundle for signed_accum_adder.
// The master drives operands and control; the slave (the adder) returns results.
interface signed_accum_adder_if #(
   parameter int N     = 4,
   parameter int CNT_W = 4
);
   logic                 in_valid;
   logic signed [N-1:0]  a;
   logic signed [N-1:0]  b;
   logic                 mode;
   logic                 clr;
   logic                 out_valid;
   logic signed [N:0]    c;
   logic                 ovf;
   logic [CNT_W-1:0]     acc_count;

   modport master (
      output in_valid, a, b, mode, clr,
      input  out_valid, c, ovf, acc_count
   );

   modport slave (
      input  in_valid, a, b, mode, clr,
      output out_valid, c, ovf, acc_count
   );
endinterface

// File: rtl/signed_accum_adder.sv
// Registered signed adder / accumulator.
// mode 0: c = a + b at N+1 bits.  mode 1: acc = acc + a with wrap or clamp
// on overflow, a sticky overflow flag and a saturating accumulate counter.
// The accumulator loop is always single-cycle; PIPE only delays c/out_valid.
module signed_accum_adder #(
   parameter int N     = 4,
   parameter int PIPE  = 1,
   parameter int SAT   = 0,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   signed_accum_adder_if.slave bus
);

   logic signed [N:0]    acc;
   logic                 ovf_q;
   logic [CNT_W-1:0]     cnt_q;

   logic signed [N:0]    acc_base;
   logic                 ovf_base;
   logic [CNT_W-1:0]     cnt_base;
   logic [CNT_W-1:0]     cnt_next;
   logic signed [N:0]    add_res;
   logic signed [N+1:0]  sum;
   logic                 over_pos;
   logic                 over_neg;
   logic signed [N:0]    acc_next;

   logic signed [N:0]    c1;
   logic                 v1;

   // Next-state arithmetic; clr zeroes the accumulator view before the add
   // so a clearing accumulate starts from sext(a).
   always_comb begin
      acc_base = bus.clr ? '0 : acc;
      ovf_base = bus.clr ? 1'b0 : ovf_q;
      cnt_base = bus.clr ? '0 : cnt_q;

      add_res  = {bus.a[N-1], bus.a} + {bus.b[N-1], bus.b};
      sum      = {acc_base[N], acc_base} + {{2{bus.a[N-1]}}, bus.a};

      // Top two bits disagree only when the N+2-bit sum left the N+1-bit range.
      over_pos = ~sum[N+1] &  sum[N];
      over_neg =  sum[N+1] & ~sum[N];

      if (over_pos && (SAT != 0))
         acc_next = {1'b0, {N{1'b1}}};
      else if (over_neg && (SAT != 0))
         acc_next = {1'b1, {N{1'b0}}};
      else
         acc_next = sum[N:0];

      cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
   end

   // Accumulator state: updated by accepted accumulates, cleared by clr otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (bus.in_valid && bus.mode) begin
         acc   <= acc_next;
         ovf_q <= ovf_base | over_pos | over_neg;
         cnt_q <= cnt_next;
      end else if (bus.clr) begin
         acc   <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end
   end

   // First result stage: captures the result on accept, holds c otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid)
            c1 <= bus.mode ? acc_next : add_res;
      end
   end

   generate
      if (PIPE == 2) begin : g_pipe2
         logic signed [N:0] c2;
         logic              v2;

         // Extra output stage; c1 already holds between accepts, so copy it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               c2 <= '0;
               v2 <= 1'b0;
            end else begin
               c2 <= c1;
               v2 <= v1;
            end
         end

         assign bus.c         = c2;
         assign bus.out_valid = v2;
      end else begin : g_pipe1
         assign bus.c         = c1;
         assign bus.out_valid = v1;
      end
   endgenerate

   // Flags track the accepting edge, independent of output latency.
   assign bus.ovf       = ovf_q;
   assign bus.acc_count = cnt_q;

endmodule

// File: tb/tb_signed_accum_adder.sv
// Bench for signed_accum_adder: three instances (SAT=1/PIPE=1, SAT=0/PIPE=1,
// SAT=0/PIPE=2) driven with directed vectors; expected results are queued at
// issue time and popped by an independent output monitor.
module tb_signed_accum_adder;

   typedef struct {
      logic signed [4:0] c;
      logic              ovf;
      logic [3:0]        cnt;
      bit                side;
   } exp_t;

   logic clk;
   logic rst;
   logic rst_p;

   logic              iv_s   [3];
   logic              mode_s [3];
   logic              clr_s  [3];
   logic signed [3:0] a_s    [3];
   logic signed [3:0] b_s    [3];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int checks = 0;
   int errors = 0;

   signed_accum_adder_if #(.N(4), .CNT_W(4)) if0 ();
   signed_accum_adder_if #(.N(4), .CNT_W(4)) if1 ();
   signed_accum_adder_if #(.N(4), .CNT_W(4)) if2 ();

   assign if0.in_valid = iv_s[0];
   assign if0.mode     = mode_s[0];
   assign if0.clr      = clr_s[0];
   assign if0.a        = a_s[0];
   assign if0.b        = b_s[0];
   assign if1.in_valid = iv_s[1];
   assign if1.mode     = mode_s[1];
   assign if1.clr      = clr_s[1];
   assign if1.a        = a_s[1];
   assign if1.b        = b_s[1];
   assign if2.in_valid = iv_s[2];
   assign if2.mode     = mode_s[2];
   assign if2.clr      = clr_s[2];
   assign if2.a        = a_s[2];
   assign if2.b        = b_s[2];

   signed_accum_adder #(.N(4), .PIPE(1), .SAT(1), .CNT_W(4)) u0 (.clk(clk), .rst(rst),   .bus(if0));
   signed_accum_adder #(.N(4), .PIPE(1), .SAT(0), .CNT_W(4)) u1 (.clk(clk), .rst(rst),   .bus(if1));
   signed_accum_adder #(.N(4), .PIPE(2), .SAT(0), .CNT_W(4)) u2 (.clk(clk), .rst(rst_p), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic mon_one(input int k, input logic v, input logic signed [4:0] cv,
                          input logic o, input logic [3:0] cn);
      exp_t e;
      bit   have;
      if (v !== 1'b1) return;
      have = 0;
      case (k)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
      endcase
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL dut%0d unexpected out_valid got c=%0d expected no pulse", k, cv);
         return;
      end
      if (cv !== e.c) begin
         errors++;
         $display("FAIL dut%0d c got %0d expected %0d", k, cv, e.c);
      end
      if (e.side) begin
         checks++;
         if (o !== e.ovf || cn !== e.cnt) begin
            errors++;
            $display("FAIL dut%0d flags got ovf=%0d cnt=%0d expected ovf=%0d cnt=%0d",
                     k, o, cn, e.ovf, e.cnt);
         end
      end
   endtask

   // Output monitor: pops one expectation per out_valid pulse.
   initial begin
      forever begin
         @(negedge clk);
         mon_one(0, if0.out_valid, if0.c, if0.ovf, if0.acc_count);
         mon_one(1, if1.out_valid, if1.c, if1.ovf, if1.acc_count);
         mon_one(2, if2.out_valid, if2.c, if2.ovf, if2.acc_count);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // chk_mode: 0 = queue c only, 1 = queue c plus ovf/acc_count, 2 = queue nothing.
   task automatic issue(input int k, input logic m, input int av, input int bv, input logic cl,
                        input int ec, input logic eo, input int en, input int chk_mode);
      exp_t e;
      iv_s[k]   = 1'b1;
      mode_s[k] = m;
      a_s[k]    = av[3:0];
      b_s[k]    = bv[3:0];
      clr_s[k]  = cl;
      e.c    = ec[4:0];
      e.ovf  = eo;
      e.cnt  = en[3:0];
      e.side = (chk_mode == 1);
      if (chk_mode != 2) begin
         case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
      @(negedge clk);
      iv_s[k]  = 1'b0;
      clr_s[k] = 1'b0;
   endtask

   task automatic clear_only(input int k);
      iv_s[k]  = 1'b0;
      clr_s[k] = 1'b1;
      @(negedge clk);
      clr_s[k] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_c0"},  int'(if0.c), 0);
      chk({tag, "_v0"},  int'(if0.out_valid), 0);
      chk({tag, "_o0"},  int'(if0.ovf), 0);
      chk({tag, "_n0"},  int'(if0.acc_count), 0);
      chk({tag, "_c1"},  int'(if1.c), 0);
      chk({tag, "_v1"},  int'(if1.out_valid), 0);
      chk({tag, "_o1"},  int'(if1.ovf), 0);
      chk({tag, "_n1"},  int'(if1.acc_count), 0);
      chk({tag, "_c2"},  int'(if2.c), 0);
      chk({tag, "_v2"},  int'(if2.out_valid), 0);
      chk({tag, "_o2"},  int'(if2.ovf), 0);
      chk({tag, "_n2"},  int'(if2.acc_count), 0);
   endtask

   initial begin
      rst   = 1'b1;
      rst_p = 1'b1;
      for (int k = 0; k < 3; k++) begin
         iv_s[k] = 1'b1; mode_s[k] = 1'b0; clr_s[k] = 1'b0;
         a_s[k] = 4'sd7; b_s[k] = 4'sd7;
      end

      // Reset held with live operands: everything stays zero.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_all_zero("rst");
      end
      for (int k = 0; k < 3; k++) iv_s[k] = 1'b0;
      rst   = 1'b0;
      rst_p = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_all_zero("idle");
      end

      // Mode 0 corners on the wrapping instance.
      issue(1, 1'b0,  7, -8, 1'b0,  -1, 1'b0, 0, 1);
      issue(1, 1'b0,  7,  0, 1'b0,   7, 1'b0, 0, 1);
      issue(1, 1'b0,  7,  7, 1'b0,  14, 1'b0, 0, 1);
      issue(1, 1'b0,  0, -8, 1'b0,  -8, 1'b0, 0, 1);
      issue(1, 1'b0, -8, -8, 1'b0, -16, 1'b0, 0, 1);
      issue(1, 1'b0, -8,  7, 1'b0,  -1, 1'b0, 0, 1);
      idle(1);

      // Saturating accumulate: clamp high, recover, then clamp low.
      issue(0, 1'b1,  7, 0, 1'b0,   7, 1'b0, 1, 1);
      issue(0, 1'b1,  7, 0, 1'b0,  14, 1'b0, 2, 1);
      issue(0, 1'b1,  7, 0, 1'b0,  15, 1'b1, 3, 1);
      issue(0, 1'b1, -8, 0, 1'b0,   7, 1'b1, 4, 1);
      issue(0, 1'b1, -8, 0, 1'b1,  -8, 1'b0, 1, 1);
      issue(0, 1'b1, -8, 0, 1'b0, -16, 1'b0, 2, 1);
      issue(0, 1'b1, -8, 0, 1'b0, -16, 1'b1, 3, 1);
      idle(1);

      // Wrapping accumulate.
      issue(1, 1'b1, 7, 0, 1'b0,   7, 1'b0, 1, 1);
      issue(1, 1'b1, 7, 0, 1'b0,  14, 1'b0, 2, 1);
      issue(1, 1'b1, 7, 0, 1'b0, -11, 1'b1, 3, 1);
      clear_only(1);
      chk("clr_only_c",   int'(if1.c), -11);
      chk("clr_only_v",   int'(if1.out_valid), 0);
      chk("clr_only_ovf", int'(if1.ovf), 0);
      chk("clr_only_cnt", int'(if1.acc_count), 0);
      issue(1, 1'b1, -8, 0, 1'b0,  -8, 1'b0, 1, 1);
      issue(1, 1'b1, -8, 0, 1'b0, -16, 1'b0, 2, 1);
      issue(1, 1'b1, -8, 0, 1'b0,   8, 1'b1, 3, 1);

      // clr together with an accepted operation.
      issue(1, 1'b1,  7, 0, 1'b1,  7, 1'b0, 1, 1);
      issue(1, 1'b1,  7, 0, 1'b0, 14, 1'b0, 2, 1);
      issue(1, 1'b1, -3, 0, 1'b1, -3, 1'b0, 1, 1);
      issue(1, 1'b0,  3, 2, 1'b1,  5, 1'b0, 0, 1);
      issue(1, 1'b1,  1, 0, 1'b0,  1, 1'b0, 1, 1);

      // Counter saturation at 15.
      issue(1, 1'b1, 0, 0, 1'b1, 0, 1'b0, 1, 1);
      for (int i = 2; i <= 17; i++)
         issue(1, 1'b1, 0, 0, 1'b0, 0, 1'b0, (i > 15) ? 15 : i, 1);
      idle(1);

      // PIPE=2: back-to-back accumulates, flags lead the delayed result.
      issue(2, 1'b1, 1, 0, 1'b0, 1, 1'b0, 0, 0);
      issue(2, 1'b1, 2, 0, 1'b0, 3, 1'b0, 0, 0);
      issue(2, 1'b1, 3, 0, 1'b0, 6, 1'b0, 0, 0);
      chk("p2_cnt_early", int'(if2.acc_count), 3);
      chk("p2_c_lag",     int'(if2.c), 3);
      idle(3);

      // PIPE=2 with reset between the second and third output edges.
      issue(2, 1'b1, 1, 0, 1'b1, 1, 1'b0, 0, 0);
      issue(2, 1'b1, 2, 0, 1'b0, 3, 1'b0, 0, 0);
      issue(2, 1'b1, 3, 0, 1'b0, 6, 1'b0, 0, 2);
      #2;
      rst_p = 1'b1;
      #1;
      chk("p2_rst_c",   int'(if2.c), 0);
      chk("p2_rst_v",   int'(if2.out_valid), 0);
      chk("p2_rst_cnt", int'(if2.acc_count), 0);
      idle(2);
      rst_p = 1'b0;
      idle(4);
      issue(2, 1'b1, 5, 0, 1'b0, 5, 1'b0, 0, 0);
      idle(4);

      chk("q0_left", q0.size(), 0);
      chk("q1_left", q1.size(), 0);
      chk("q2_left", q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/signed_accum_adder.md
# signed_accum_adder

Parametrised registered signed adder/accumulator for the arithmetic datapath. It generalises the 4-bit registered signed adder with synchronous-to-clock output to N-bit operands. It adds a valid handshake, an accumulate mode with wrap or saturate overflow handling, a sticky overflow flag, an accumulation counter and a selectable output pipeline depth.

## Interface
- N, default 4: operand width in bits, signed two's complement; minimum 2.
- PIPE, default 1: output latency in cycles; legal values 1 or 2.
- SAT, default 0: accumulate overflow policy; 0 = wrap, 1 = clamp.
- CNT_W, default 4: width of the accumulation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- in_valid  in  1  operand strobe; inputs are accepted on any rising edge where in_valid=1.
- a  in  N  signed operand A.
- b  in  N  signed operand B; used in mode 0 only.
- mode  in  1  0 = add (c = a+b); 1 = accumulate (acc = acc+a).
- clr  in  1  synchronous clear of acc, ovf and acc_count.
- out_valid  out  1  one-cycle pulse per accepted input, PIPE cycles after accept.
- c  out  N+1  signed result.
- ovf  out  1  sticky accumulate-overflow flag.
- acc_count  out  CNT_W  number of accepted accumulate operations since the last clear.

## Operation
- Reset values: c=0, out_valid=0, ovf=0, acc_count=0, internal acc=0, all pipeline registers=0.
- Mode 0, accept:
  - Result = sext(a)+sext(b) at N+1 bits; it cannot overflow.
  - acc, ovf and acc_count are unchanged.
- Mode 1, accept:
  - Sum = acc + sext(a), computed at N+2 bits.
  - If the sum lies in [-2^N, 2^N-1], acc takes the sum.
  - Otherwise, with SAT=1, acc is clamped to 2^N-1 or -2^N, whichever side was exceeded.
  - Otherwise, with SAT=0, acc takes the low N+1 bits of the sum (wrap).
  - In either out-of-range case, ovf is set to 1 and stays set until clr or rst.
  - The result is the new acc value.
  - acc_count increments and saturates at 2^CNT_W-1; it does not wrap.
- clr without in_valid: acc, ovf and acc_count become 0 at the next edge; c and out_valid are unaffected.
- clr with in_valid, mode 1: clear applies first, so acc = sext(a), acc_count = 1, and ovf = 0.
- clr with in_valid, mode 0: the add proceeds normally and the accumulator state is cleared.
- in_valid=0: no state change other than clr; out_valid is 0 in the corresponding output cycle; c holds its last value.
- mode is sampled only when in_valid=1.

## Timing
- PIPE=1: c and out_valid update on the edge that accepts the input. They are visible after that edge, so a check at the following negedge sees them.
- PIPE=2: one extra register stage on c and out_valid, so they are visible one edge later. The accumulator feedback stays single-cycle, so back-to-back accumulates every cycle are legal.
- Throughput: one operation per cycle; no backpressure.
- ovf and acc_count update on the accepting edge regardless of PIPE. They are not delayed with c.
- rst asserted mid-operation:
  - All outputs go to 0 without waiting for a clock edge.
  - Any in-flight pipeline results are discarded; no out_valid pulse follows.
  - Operation resumes on the first edge after rst deasserts.

## Test plan
- Reset and idle:
  - Assert rst with a=7, b=7, in_valid=1 -> c=0, out_valid=0, ovf=0, acc_count=0 throughout.
  - Release rst, keep in_valid=0 for 3 cycles -> c stays 0.
- Mode 0 corners (N=4, PIPE=1):
  - (7,-8) -> -1; (7,0) -> 7; (7,7) -> 14; (0,-8) -> -8; (-8,-8) -> -16; (-8,7) -> -1.
  - Each result appears one edge after accept with out_valid=1; ovf stays 0.
- Accumulate overflow, SAT=1:
  - Feed a=7 three times in mode 1 -> c=7, 14, 15; ovf=1 from the third edge; acc_count=3.
  - Then feed a=-8 -> c=7; ovf stays 1.
- Accumulate overflow, SAT=0:
  - Feed a=7 three times -> c=7, 14, -11; ovf=1.
  - Feed a=-8 twice from clear -> c=-8, -16.
  - A third -8 -> c=8 (wrap); ovf=1.
- clr interaction:
  - From acc=14, assert clr with in_valid=1, mode=1, a=-3 -> c=-3, acc_count=1, ovf=0.
  - Sixteen a=0 accumulates with CNT_W=4 -> acc_count sticks at 15.
- PIPE=2 and mid-stream reset:
  - Back-to-back accumulates a=1,2,3 -> c=1, 3, 6 at edges 2, 3, 4 after the first accept.
  - Assert rst between the second and third output edges -> c=0 immediately; no further out_valid.
